// File: rtl/wshb_resp_pkg.sv
// ============================================================================
// Module  : wshb_resp_pkg
// Brief   : Shared types and constants for the Wishbone stream responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wshb_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        RESP  = 2'd2
    } resp_state_t;

    // Bit positions inside the read-back status word
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_LEVEL_LSB = 8;

    localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

`default_nettype wire

// File: rtl/wshb_stream_responder_if.sv
// ============================================================================
// Module  : wshb_stream_responder_if
// Brief   : Wishbone classic bus bundle for the video stream bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface wshb_stream_responder_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, sel, dat_ms, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

`default_nettype wire

// File: rtl/wshb_stream_responder_sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with wrap-bit pointers and a fill-level output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_level
);

    localparam int            c_AW  = $clog2(DEPTH);
    localparam logic [c_AW:0] c_ONE = (c_AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
    end

    // Same index with differing wrap bits means the writer is a full lap ahead
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_rdata = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/wshb_stream_responder.sv
// ============================================================================
// Module  : wshb_stream_responder
// Brief   : Wishbone classic slave that buffers stream write beats into a FIFO
//           drained through a valid/ready pixel port; reads return status.
//           Optional: WSHB_RESP_RTY_EN - full-FIFO writes get rty, not a stall.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wshb_stream_responder
    import wshb_resp_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter int          DATA_BYTES = 4,
    parameter logic [31:0] SOF_ADR    = 32'h0
) (
    input  wire logic              sys_clk,
    input  wire logic              sys_rst_n,
    wshb_stream_responder_if.slave bus,
    output logic [31:0]            pix_data,
    output logic                   pix_sof,
    output logic                   pix_valid,
    input  wire logic              pix_ready
);

    localparam int         c_DW       = 8 * DATA_BYTES;
    localparam int         c_LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_STALL = STALL;
    localparam logic [1:0] c_ST_RESP  = RESP;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nx;
    logic            r_ack;
    logic            r_err;
    logic            r_rty;
    logic            w_ack_nx;
    logic            w_err_nx;
    logic            w_rty_nx;
    logic [31:0]     r_dat;
    logic [31:0]     w_dat_nx;
    logic [31:0]     w_status;
    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [c_LW-1:0] w_level;
    logic [c_DW:0]   w_fifo_wdata;
    logic [c_DW:0]   w_fifo_rdata;
    logic            w_unused;

    assign w_unused     = ^{bus.cti, bus.bte};
    assign w_fifo_wdata = {bus.adr == SOF_ADR, bus.dat_ms};
    assign w_pop        = ~w_empty & pix_ready;

    always_comb begin
        w_status                         = '0;
        w_status[STAT_EMPTY]             = w_empty;
        w_status[STAT_FULL]              = w_full;
        w_status[STAT_LEVEL_LSB +: 8]    = 8'(w_level);
    end

    always_comb begin
        w_req      = bus.cyc & bus.stb & ~(r_ack | r_err | r_rty);
        w_state_nx = r_state;
        w_push     = 1'b0;
        w_ack_nx   = 1'b0;
        w_err_nx   = 1'b0;
        w_rty_nx   = 1'b0;
        w_dat_nx   = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req) begin
                    if (!bus.we) begin
                        w_ack_nx   = 1'b1;
                        w_dat_nx   = w_status;
                        w_state_nx = c_ST_RESP;
                    end else if (bus.sel != SEL_ALL) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = c_ST_RESP;
                    end else if (!w_full) begin
                        w_push     = 1'b1;
                        w_ack_nx   = 1'b1;
                        w_state_nx = c_ST_RESP;
                    end else begin
`ifdef WSHB_RESP_RTY_EN
                        w_rty_nx   = 1'b1;
                        w_state_nx = c_ST_RESP;
`else
                        w_state_nx = c_ST_STALL;
`endif
                    end
                end
            end
            c_ST_STALL: begin
                // A master that gives up the cycle while stalled loses the beat
                if (!bus.cyc) begin
                    w_state_nx = c_ST_IDLE;
                end else if (!w_full) begin
                    w_push     = 1'b1;
                    w_ack_nx   = 1'b1;
                    w_state_nx = c_ST_RESP;
                end
            end
            c_ST_RESP: w_state_nx = c_ST_IDLE;
            default:   w_state_nx = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= c_ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ack   <= w_ack_nx;
            r_err   <= w_err_nx;
            r_rty   <= w_rty_nx;
            r_dat   <= w_dat_nx;
        end
    end

    assign bus.ack    = r_ack;
    assign bus.err    = r_err;
    assign bus.dat_sm = r_dat;
`ifdef WSHB_RESP_RTY_EN
    assign bus.rty    = r_rty;
`else
    assign bus.rty    = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (c_DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .i_push  (w_push),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign pix_valid = ~w_empty;
    assign pix_data  = w_empty ? '0 : w_fifo_rdata[c_DW-1:0];
    assign pix_sof   = ~w_empty & w_fifo_rdata[c_DW];

endmodule

`default_nettype wire

// File: tb/tb_wshb_stream_responder.sv
// ============================================================================
// Module  : tb_wshb_stream_responder
// Brief   : Self-checking bench for wshb_stream_responder (queue-level model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wshb_stream_responder;

    localparam int DEPTH = 16;
    localparam int TMO   = 50;
    localparam int P_NONE = 0, P_WR = 1, P_BAD = 2, P_RD = 3;
`ifdef WSHB_RESP_RTY_EN
    localparam bit RTY_EN = 1'b1;
`else
    localparam bit RTY_EN = 1'b0;
`endif

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready = 1'b0;

    wshb_stream_responder_if bus ();

    wshb_stream_responder #(
        .FIFO_DEPTH (DEPTH),
        .DATA_BYTES (4),
        .SOF_ADR    (32'h0)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready)
    );

    always #5 sys_clk = ~sys_clk;

    // Requests posted by the driver; the model serves them edge by edge
    int          pend_kind = P_NONE;
    int          pend_seq  = 0;
    int          served_seq = 0;
    logic [31:0] p_adr, p_dat;

    logic [32:0] q[$];
    logic        e_ack = 1'b0, e_err = 1'b0, e_rty = 1'b0;
    logic [31:0] e_dat = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge sys_clk) begin : m_model
        int  lvl;
        bit  was_full, was_empty;
        lvl       = q.size();
        was_full  = (lvl == DEPTH);
        was_empty = (lvl == 0);
        e_ack = 1'b0; e_err = 1'b0; e_rty = 1'b0; e_dat = '0;
        if (!sys_rst_n) begin
            q.delete();
            served_seq = pend_seq;
        end else begin
            if (pix_ready && !was_empty) void'(q.pop_front());
            if (pend_seq != served_seq && pend_kind != P_NONE) begin
                if (pend_kind == P_RD) begin
                    e_ack = 1'b1;
                    e_dat = lvl * 256 + (was_full ? 2 : 0) + (was_empty ? 1 : 0);
                    served_seq = pend_seq;
                end else if (pend_kind == P_BAD) begin
                    e_err = 1'b1;
                    served_seq = pend_seq;
                end else if (!was_full) begin
                    q.push_back({p_adr == 32'h0, p_dat});
                    e_ack = 1'b1;
                    served_seq = pend_seq;
                end else if (RTY_EN) begin
                    e_rty = 1'b1;
                    served_seq = pend_seq;
                end
            end
        end
    end

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic wait_term(input int abandon, output logic [31:0] rdat);
        int n = 0;
        bit done = 0;
        rdat = '0;
        while (!done) begin
            @(negedge sys_clk);
            n++;
            if (bus.ack || bus.err || bus.rty) begin
                rdat = bus.dat_sm;
                done = 1;
            end else if (abandon > 0 && n >= abandon) begin
                done = 1;
            end else if (n >= TMO) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wb_timeout: no termination after %0d cycles, required within %0d", n, TMO);
                done = 1;
            end
        end
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        pend_kind = P_NONE;
        @(negedge sys_clk);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int abandon);
        logic [31:0] unused_rd;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = adr; bus.dat_ms = dat; bus.sel = sel;
        p_adr = adr; p_dat = dat;
        pend_kind = (sel == 4'hF) ? P_WR : P_BAD;
        pend_seq++;
        wait_term(abandon, unused_rd);
    endtask

    task automatic wb_read(output logic [31:0] rdat);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
        bus.adr = 32'h0; bus.sel = 4'hF;
        pend_kind = P_RD;
        pend_seq++;
        wait_term(0, rdat);
    endtask

    task automatic pop_cycles(input int n);
        pix_ready = 1'b1;
        repeat (n) @(negedge sys_clk);
        pix_ready = 1'b0;
    endtask

    initial begin : m_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : m_main
        logic [31:0] st;
        logic [31:0] full_stat;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.adr = '0; bus.sel = '0; bus.dat_ms = '0;
        bus.cti = 3'b0; bus.bte = 2'b0;
        repeat (3) @(negedge sys_clk);

        fork
            forever begin
                @(negedge sys_clk);
                check("ack",       bus.ack,    e_ack);
                check("err",       bus.err,    e_err);
                check("rty",       bus.rty,    e_rty);
                check("dat_sm",    bus.dat_sm, e_dat);
                check("pix_valid", pix_valid,  q.size() != 0);
                check("pix_data",  pix_data,   (q.size() != 0) ? q[0][31:0] : 32'h0);
                check("pix_sof",   pix_sof,    (q.size() != 0) ? q[0][32]   : 1'b0);
            end
        join_none

        check("reset_valid", pix_valid, 1'b0);
        check("reset_ack",   bus.ack,   1'b0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Single SOF write, then consume it
        wb_write(32'h0, 32'hDEADBEEF, 4'hF, 0);
        check("first_valid", pix_valid, 1'b1);
        check("first_data",  pix_data,  32'hDEADBEEF);
        check("first_sof",   pix_sof,   1'b1);
        pop_cycles(1);
        check("first_popped", pix_valid, 1'b0);

        // Fill to 16 words
        for (int i = 0; i < DEPTH; i++) wb_write(32'h4, 32'hA000_0000 + i, 4'hF, 0);
        wb_read(st);
        check("status_full", st, 32'h0000_1002);
        if (RTY_EN) begin
            wb_write(32'h4, 32'hCAFE_0001, 4'hF, 0);
            wb_read(st);
            check("status_after_rty", st, 32'h0000_1002);
        end

        // 17th write while a single pop happens a few cycles later
        fork
            wb_write(32'h4, 32'hA000_0010, 4'hF, 0);
            begin
                repeat (5) @(negedge sys_clk);
                pix_ready = 1'b1;
                @(negedge sys_clk);
                pix_ready = 1'b0;
            end
        join
        full_stat = RTY_EN ? 32'h0000_0F00 : 32'h0000_1002;
        wb_read(st);
        check("status_after_17th", st, full_stat);

        // Partial byte select is refused
        wb_write(32'h4, 32'h5555_5555, 4'h3, 0);
        wb_read(st);
        check("status_after_err", st, full_stat);

        // Abandon a (stalled) beat, pop one, then write a fresh word
        wb_write(32'h4, 32'hBAD0_BAD0, 4'hF, 4);
        pop_cycles(1);
        wb_write(32'h4, 32'h1234_5678, 4'hF, 0);
        wb_read(st);
        check("status_after_abandon", st, 32'h0000_1002);

        pop_cycles(DEPTH + 4);
        wb_read(st);
        check("status_empty", st, 32'h0000_0001);

        // Three words, SOF at the head
        wb_write(32'h0, 32'h1111_0000, 4'hF, 0);
        wb_write(32'h4, 32'h1111_0001, 4'hF, 0);
        wb_write(32'h8, 32'h1111_0002, 4'hF, 0);
        wb_read(st);
        check("status_three", st, 32'h0000_0300);
        check("three_head_data", pix_data, 32'h1111_0000);
        check("three_head_sof",  pix_sof,  1'b1);

        // Reset in the middle of a write beat
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = 32'h4; bus.dat_ms = 32'h7777_7777; bus.sel = 4'hF;
        p_adr = 32'h4; p_dat = 32'h7777_7777;
        pend_kind = P_WR;
        pend_seq++;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("midrst_ack",    bus.ack,    1'b0);
        check("midrst_err",    bus.err,    1'b0);
        check("midrst_rty",    bus.rty,    1'b0);
        check("midrst_dat_sm", bus.dat_sm, 32'h0);
        check("midrst_valid",  pix_valid,  1'b0);
        check("midrst_sof",    pix_sof,    1'b0);
        check("midrst_data",   pix_data,   32'h0);
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        pend_kind = P_NONE;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        wb_write(32'h10, 32'h0BAD_F00D, 4'hF, 0);
        wb_read(st);
        check("status_post_reset", st, 32'h0000_0100);
        check("post_reset_sof", pix_sof, 1'b0);
        pop_cycles(2);
        repeat (2) @(negedge sys_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
